load_store_unit: RTL and testbench

- Sits between the core's execute stage and data_mem.
- Accepts one load/store request at a time through a valid/ready handshake and drives data_mem's mem_read, mem_write, addr and write_data.
- data_mem always reads and writes 4 bytes at the given byte address, with 1-cycle registered read. This block adds:
  - byte/half access via read-modify-write,
  - load sign/zero extension,
  - bounds checking.
- Returns a one-cycle response pulse. The core stalls while req_ready is low.

---
 rtl/lsu_pkg.sv | 34 +++
 rtl/lsu_data_align.sv | 37 +++
 rtl/load_store_unit.sv | 158 +++++++++++++++
 tb/tb_load_store_unit.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store unit.
//   lsu_size_e  - request access size (byte, half, word, reserved)
//   lsu_state_e - load/store FSM states
//   LSU_MEM_BYTES - default data_mem size in bytes
//   lsu_misaligned() - alignment predicate, used only when LSU_MISALIGN_TRAP_EN is defined
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } lsu_size_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    LD_DONE = 3'd2,
    WR      = 3'd3,
    RMW_WR  = 3'd4
  } lsu_state_e;

  localparam int LSU_MEM_BYTES = 256;

  // A half must sit on an even address, a word on a 4-byte boundary.
  function automatic logic lsu_misaligned(input lsu_size_e size, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    if (size == SZ_HALF && addr_lo[0]) mis = 1'b1;
    if (size == SZ_WORD && addr_lo != 2'b00) mis = 1'b1;
    return mis;
  endfunction

endpackage

// File: rtl/lsu_data_align.sv
// lsu_data_align: purely combinational data path of the load/store unit.
//   size        in  access size of the latched request
//   is_unsigned in  zero-extend byte/half loads instead of sign-extending
//   rdata       in  32-bit word returned by data_mem
//   wdata       in  store data from the request (LSBs used for byte/half)
//   load_data   out rdata's low byte/half/word, extended to 32 bits
//   store_data  out rdata with the low byte/half replaced by wdata (word: wdata)
module lsu_data_align
  import lsu_pkg::*;
(
  input  lsu_size_e   size,
  input  logic        is_unsigned,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  always_comb begin
    load_data = rdata;
    case (size)
      SZ_BYTE: load_data = {{24{rdata[7] & ~is_unsigned}}, rdata[7:0]};
      SZ_HALF: load_data = {{16{rdata[15] & ~is_unsigned}}, rdata[15:0]};
      default: load_data = rdata;
    endcase
  end

  always_comb begin
    store_data = wdata;
    case (size)
      SZ_BYTE: store_data = {rdata[31:8], wdata[7:0]};
      SZ_HALF: store_data = {rdata[31:16], wdata[15:0]};
      default: store_data = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: bridges the execute stage to a word-wide data_mem with a
// 1-cycle registered read. Adds byte/half stores by read-modify-write,
// sign/zero extension of loads and a bounds check.
//
// Optional build macro: LSU_MISALIGN_TRAP_EN - when defined, a half at an odd
// address or a word not on a 4-byte boundary is rejected with rsp_err.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   req_valid/ready    request handshake
//   req_we, req_size, req_unsigned, req_addr, req_wdata   request fields
//   rsp_valid          one-cycle response pulse (no backpressure)
//   rsp_rdata, rsp_err extended load data / rejected request flag
//   mem_read, mem_write, mem_addr, mem_wdata   drive to data_mem
//   mem_rdata          data_mem read data, valid the cycle after mem_read
//
// Handshake: a request transfers on any rising edge where req_valid && req_ready.
// req_ready is high exactly while the FSM is IDLE, including the cycle that
// carries rsp_valid, so back-to-back requests lose no cycle. Request inputs are
// latched at transfer and ignored afterwards.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = LSU_MEM_BYTES,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  // data_mem always touches 4 bytes, so even a byte access must fit a word.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_BYTES - 4);

  lsu_state_e        state, state_next;
  logic              lat_we;
  lsu_size_e         lat_size;
  logic              lat_unsigned;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;

  logic              req_fire;
  logic              req_err;
  logic              rsp_done;
  logic [31:0]       load_data;
  logic [31:0]       store_data;

  assign req_ready = (state == IDLE);
  assign req_fire  = req_valid && req_ready;

  always_comb begin
    req_err = 1'b0;
    if (lsu_size_e'(req_size) == SZ_RSVD) req_err = 1'b1;
    if (req_addr > LAST_ADDR) req_err = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
    if (lsu_misaligned(lsu_size_e'(req_size), req_addr[1:0])) req_err = 1'b1;
`else
`endif
  end

  lsu_data_align u_align (
    .size        (lat_size),
    .is_unsigned (lat_unsigned),
    .rdata       (mem_rdata),
    .wdata       (lat_wdata),
    .load_data   (load_data),
    .store_data  (store_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and memory strobes. Strobes depend only on state and the
  // latched request, so reset drops them at once.
  always_comb begin
    state_next = state;
    rsp_done   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state)
      IDLE: begin
        if (req_fire && !req_err) begin
          // Word stores write directly; everything else needs the old word.
          if (req_we && lsu_size_e'(req_size) == SZ_WORD) state_next = WR;
          else                                             state_next = RD;
        end
      end
      RD: begin
        mem_read   = 1'b1;
        mem_addr   = lat_addr;
        state_next = lat_we ? RMW_WR : LD_DONE;
      end
      LD_DONE: begin
        rsp_done   = 1'b1;
        state_next = IDLE;
      end
      WR, RMW_WR: begin
        mem_write  = 1'b1;
        mem_addr   = lat_addr;
        mem_wdata  = store_data;
        rsp_done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_we       <= 1'b0;
      lat_size     <= SZ_BYTE;
      lat_unsigned <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
    end else if (req_fire) begin
      lat_we       <= req_we;
      lat_size     <= lsu_size_e'(req_size);
      lat_unsigned <= req_unsigned;
      lat_addr     <= req_addr;
      lat_wdata    <= req_wdata;
    end
  end

  // A rejected request never leaves IDLE; it answers on the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= rsp_done || (req_fire && req_err);
      rsp_err   <= req_fire && req_err;
      rsp_rdata <= (state == LD_DONE) ? load_data : '0;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: bench for load_store_unit with a behavioural data_mem
// (4-byte access, 1-cycle registered read) and a reference byte array that
// predicts every response, write word, latency and strobe count.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  load_store_unit #(.MEM_BYTES(256), .ADDR_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  // ---------------- clock / reset ----------------
  int cyc;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- data_mem model ----------------
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  logic       pre_we;
  logic [7:0] pre_addr;
  logic [7:0] pre_data;

  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end else if (mem_write) begin
      mem[mem_addr[7:0]]        <= mem_wdata[7:0];
      mem[mem_addr[7:0] + 8'd1] <= mem_wdata[15:8];
      mem[mem_addr[7:0] + 8'd2] <= mem_wdata[23:16];
      mem[mem_addr[7:0] + 8'd3] <= mem_wdata[31:24];
    end
    if (mem_read) begin
      mem_rdata <= {mem[mem_addr[7:0] + 8'd3], mem[mem_addr[7:0] + 8'd2],
                    mem[mem_addr[7:0] + 8'd1], mem[mem_addr[7:0]]};
    end
  end

  // ---------------- checking ----------------
  int checks;
  int failures;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];   // expected rsp_rdata
  logic [31:0] err_q[$];   // expected rsp_err
  logic [31:0] due_q[$];   // cycle in which rsp_valid must be seen
  logic [31:0] nstb_q[$];  // expected number of strobe cycles
  logic [31:0] addr_q[$];  // expected mem_addr on strobes
  logic [31:0] wd_q[$];    // expected mem_wdata on writes
  int strobes;

  always @(negedge clk) begin
    if (!rst_n) begin
      strobes = 0;
    end else begin
      if (mem_read || mem_write) begin
        strobes++;
        check_eq("strobe_overlap", {31'd0, mem_read && mem_write}, 32'd0);
        check_eq("ready_while_busy", {31'd0, req_ready}, 32'd0);
        if (addr_q.size() > 0) check_eq("mem_addr", mem_addr, addr_q[0]);
        if (mem_write && wd_q.size() > 0) check_eq("mem_wdata", mem_wdata, wd_q[0]);
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
        end else begin
          check_eq("rsp_rdata", rsp_rdata, exp_q.pop_front());
          check_eq("rsp_err", {31'd0, rsp_err}, err_q.pop_front());
          check_eq("rsp_cycle", cyc, due_q.pop_front());
          check_eq("strobe_count", strobes, nstb_q.pop_front());
          void'(addr_q.pop_front());
          void'(wd_q.pop_front());
        end
        strobes = 0;
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_word(input logic [31:0] addr);
    int a;
    a = int'(addr);
    return {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
  endfunction

  function automatic logic model_err(input logic [1:0] size, input logic [31:0] addr);
    logic e;
    e = (size == 2'b11) || (addr > 32'd252);
`ifdef LSU_MISALIGN_TRAP_EN
    if (size == 2'b01 && addr[0]) e = 1'b1;
    if (size == 2'b10 && addr[1:0] != 2'b00) e = 1'b1;
`endif
    return e;
  endfunction

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns #1 after the edge that accepted
  // the request, so consecutive calls keep req_valid high (back-to-back).
  task automatic send(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    logic err;
    logic [31:0] w, wd, rd;
    int lat, nstb, a;
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check_eq("ready_timeout", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b0;
      return;
    end
    err = model_err(size, addr);
    rd = 32'd0; wd = 32'd0;
    if (err) begin
      lat = 1; nstb = 0;
    end else begin
      w = ref_word(addr);
      if (!we) begin
        lat = 3; nstb = 1;
        case (size)
          2'b00: rd = uns ? {24'd0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
          2'b01: rd = uns ? {16'd0, w[15:0]} : {{16{w[15]}}, w[15:0]};
          default: rd = w;
        endcase
      end else begin
        case (size)
          2'b00: begin wd = {w[31:8], wdata[7:0]};   lat = 3; nstb = 2; end
          2'b01: begin wd = {w[31:16], wdata[15:0]}; lat = 3; nstb = 2; end
          default: begin wd = wdata;                 lat = 2; nstb = 1; end
        endcase
        a = int'(addr);
        ref_mem[a] = wd[7:0]; ref_mem[a+1] = wd[15:8];
        ref_mem[a+2] = wd[23:16]; ref_mem[a+3] = wd[31:24];
      end
    end
    exp_q.push_back(rd);
    err_q.push_back({31'd0, err});
    due_q.push_back(cyc + lat);
    nstb_q.push_back(nstb);
    addr_q.push_back(addr);
    wd_q.push_back(wd);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    // Fields are don't-care after accept; scramble them.
    req_we = 1'($urandom_range(0, 1)); req_size = 2'($urandom_range(0, 3));
    req_unsigned = 1'($urandom_range(0, 1)); req_addr = $urandom; req_wdata = $urandom;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check_eq("drain_timeout", exp_q.size(), 32'd0);
    idle(2);
  endtask

  task automatic preload(input int addr, input logic [7:0] data);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = 8'(addr); pre_data = data;
    ref_mem[addr] = data;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] b;
    cyc = 0; strobes = 0; checks = 0; failures = 0;
    rst_n = 1'b0; pre_we = 1'b0; pre_addr = 8'd0; pre_data = 8'd0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0;

    for (int i = 0; i < 256; i++) preload(i, 8'($urandom_range(0, 255)));
    preload(16'h10, 8'hBB); preload(16'h11, 8'hAA);
    preload(16'h12, 8'h99); preload(16'h13, 8'h88);

    // Reset values.
    @(negedge clk);
    check_eq("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("rst_rsp_rdata", rsp_rdata, 32'd0);
    check_eq("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    check_eq("rst_mem_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'd0);
    check_eq("rst_mem_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed: extension, RMW store, bounds, reserved size.
    send(1'b0, 2'b00, 1'b0, 32'h10, 32'h0);          // LB  -> FFFFFFBB
    idle(2);
    send(1'b0, 2'b00, 1'b1, 32'h10, 32'h0);          // LBU -> 000000BB
    idle(2);
    send(1'b0, 2'b01, 1'b0, 32'h11, 32'h0);          // LH 0x11
    idle(2);
    send(1'b0, 2'b01, 1'b1, 32'h11, 32'h0);          // LHU 0x11
    idle(2);
    send(1'b1, 2'b00, 1'b0, 32'h10, 32'h12345678);   // SB -> word 8899AA78
    idle(2);
    send(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);          // LW -> 8899AA78
    idle(2);
    send(1'b1, 2'b10, 1'b0, 32'hFC, 32'hDEADBEEF);   // SW at top word
    idle(2);
    send(1'b0, 2'b10, 1'b0, 32'hFC, 32'h0);          // LW -> DEADBEEF
    idle(2);
    send(1'b0, 2'b10, 1'b0, 32'hFD, 32'h0);          // out of bounds
    idle(2);
    send(1'b0, 2'b11, 1'b0, 32'h20, 32'h0);          // reserved size
    idle(2);
    send(1'b1, 2'b01, 1'b0, 32'h32, 32'hCAFEF00D);   // SH
    wait_drain();

    // Back-to-back random traffic, some out of range or reserved.
    for (int i = 0; i < 40; i++) begin
      send(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           32'($urandom_range(0, 259)), $urandom);
    end
    wait_drain();

    // Reset during the RD cycle of an SH to 0x20.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
    req_addr = 32'h20; req_wdata = 32'h0000A5A5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check_eq("rd_before_reset", {31'd0, mem_read}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("reset_drops_read", {31'd0, mem_read}, 32'd0);
    check_eq("reset_no_write", {31'd0, mem_write}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_eq("ready_after_reset", {31'd0, req_ready}, 32'd1);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      b = ref_mem[32 + i];
      check_eq("rmw_abort_mem", {24'd0, mem[32 + i]}, {24'd0, b});
    end
    @(posedge clk); #1;
    send(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);          // memory still intact
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
